// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, states and select encodings for the multi-cycle control FSM
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic PC_SEQ    = 1'b0;
  localparam logic PC_BRANCH = 1'b1;
  localparam logic WB_ALU    = 1'b0;
  localparam logic WB_MDR    = 1'b1;
  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_ALU  = 1'b1;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_L) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage

// File: rtl/instret_counter.sv
// rtl/instret_counter.sv - wrapping retired-instruction counter
module instret_counter #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [INSTRET_W-1:0] count
);

  // Count one per retiring edge; natural overflow wraps to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I-subset control FSM (optional TRAP_ILLEGAL_EN halts on bad opcode)
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 br_eq,
  input  logic                 br_nq,
  input  logic                 load,
  input  logic                 store,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_we,
  output logic                 mdr_we,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_we,
  output logic                 wb_sel,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  state_t state_q, state_nxt;
  logic   retire;
`ifdef TRAP_ILLEGAL_EN
  logic   illegal_set;
  logic   illegal_q;
`endif

  // State register; async reset drops any in-flight memory request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_nxt;
  end

  // Next-state and control decode; outputs depend on state, IR class and mem_ready.
  always_comb begin
    state_nxt    = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_PC;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SEQ;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
`ifdef TRAP_ILLEGAL_EN
    illegal_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_PC;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_supported(opcode)) begin
          state_nxt = S_EXEC;
        end else begin
`ifdef TRAP_ILLEGAL_EN
          illegal_set = 1'b1;
          state_nxt   = S_HALT;
`else
          pc_we     = 1'b1;
          pc_src    = PC_SEQ;
          retire    = 1'b1;
          state_nxt = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op    = ALU_FUNCT;
            state_nxt = S_WB;
          end
          OP_I: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_FUNCT;
            state_nxt = S_WB;
          end
          OP_L, OP_S: begin
            alu_src_b = 1'b1;
            state_nxt = S_MEM;
          end
          OP_B: begin
            alu_op    = ALU_SUB;
            pc_we     = 1'b1;
            pc_src    = (br_eq & alu_zero) | (br_nq & ~alu_zero);
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_ALU;
        mem_we       = store;
        alu_src_b    = 1'b1;
        alu_op       = ALU_ADD;
        if (mem_ready) begin
          if (opcode == OP_S) begin
            pc_we     = 1'b1;
            pc_src    = PC_SEQ;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        wb_sel    = load ? WB_MDR : WB_ALU;
        alu_src_b = (opcode != OP_R);
        alu_op    = ((opcode == OP_R) || (opcode == OP_I)) ? ALU_FUNCT : ALU_ADD;
        pc_we     = 1'b1;
        pc_src    = PC_SEQ;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef TRAP_ILLEGAL_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else if (illegal_set) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state = state_q;

  instret_counter #(.INSTRET_W(INSTRET_W)) u_instret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   opcode;
  logic         br_eq, br_nq, load, store, alu_zero, mem_ready;
  logic         mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src, alu_src_b;
  logic [1:0]   alu_op;
  logic         reg_we, wb_sel, illegal;
  logic [2:0]   state;
  logic [W-1:0] instret;
  logic [11:0]  ctrl;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;

  multicycle_ctrl #(.INSTRET_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .br_eq        (br_eq),
    .br_nq        (br_nq),
    .load         (load),
    .store        (store),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .state        (state),
    .instret      (instret),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  assign ctrl = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we,
                 pc_src, alu_src_b, alu_op, reg_we, wb_sel};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [2:0] st, input logic [11:0] c);
    #1;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(c));
  endtask

  task automatic check_ret(input string tag);
    check({tag, "_instret"}, 32'(instret), 32'(exp_ret % (1 << W)));
  endtask

  task automatic set_op(input logic [6:0] op, input logic ld, input logic st);
    opcode = op; load = ld; store = st;
    br_eq = 1'b0; br_nq = 1'b0; alu_zero = 1'b0; mem_ready = 1'b1;
  endtask

  // R/I instruction from FETCH: 4 cycles with zero-wait memory
  task automatic run_alu(input string tag, input logic [6:0] op,
                         input logic [11:0] exec_c, input logic [11:0] wb_c);
    set_op(op, 1'b0, 1'b0);
    expect_st({tag, "_fetch"}, 3'd1, 12'h900);
    tick; expect_st({tag, "_decode"}, 3'd2, 12'h000);
    tick; expect_st({tag, "_exec"}, 3'd3, exec_c);
    tick; expect_st({tag, "_wb"}, 3'd5, wb_c);
    check_ret({tag, "_pre"});
    tick; exp_ret++;
    expect_st({tag, "_next"}, 3'd1, 12'h900);
    check_ret(tag);
  endtask

  task automatic run_branch(input string tag, input logic eq, input logic nq,
                            input logic z, input logic [11:0] exec_c);
    set_op(7'b1100011, 1'b0, 1'b0);
    br_eq = eq; br_nq = nq; alu_zero = z;
    #1;
    tick; #1;
    tick; expect_st({tag, "_exec"}, 3'd3, exec_c);
    tick; exp_ret++;
    expect_st({tag, "_next"}, 3'd1, 12'h900);
    check_ret(tag);
  endtask

  initial begin
    reset = 1'b1;
    set_op(7'b0000000, 1'b0, 1'b0);
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    tick; tick;
    reset = 1'b0;
    expect_st("idle", 3'd0, 12'h000);
    tick;

    run_alu("add_r", 7'b0110011, 12'h008, 12'h04A);
    run_alu("addi", 7'b0010011, 12'h018, 12'h05A);

    run_branch("beq_taken", 1'b1, 1'b0, 1'b1, 12'h064);
    run_branch("beq_not", 1'b1, 1'b0, 1'b0, 12'h044);
    run_branch("bne_taken", 1'b0, 1'b1, 1'b0, 12'h064);

    // Load with three not-ready MEM cycles
    set_op(7'b0000011, 1'b1, 1'b0);
    expect_st("ld_fetch", 3'd1, 12'h900);
    tick; expect_st("ld_decode", 3'd2, 12'h000);
    tick; expect_st("ld_exec", 3'd3, 12'h010);
    tick; mem_ready = 1'b0;
    expect_st("ld_mem0", 3'd4, 12'hA10);
    for (int i = 0; i < 2; i++) begin
      tick; expect_st("ld_memw", 3'd4, 12'hA10);
    end
    tick; mem_ready = 1'b1;
    expect_st("ld_memrdy", 3'd4, 12'hA90);
    tick; expect_st("ld_wb", 3'd5, 12'h053);
    tick; exp_ret++;
    expect_st("ld_next", 3'd1, 12'h900);
    check_ret("ld");

    // Store with zero-wait memory
    set_op(7'b0100011, 1'b0, 1'b1);
    expect_st("st_fetch", 3'd1, 12'h900);
    tick; expect_st("st_decode", 3'd2, 12'h000);
    tick; expect_st("st_exec", 3'd3, 12'h010);
    tick; expect_st("st_mem", 3'd4, 12'hE50);
    tick; exp_ret++;
    expect_st("st_next", 3'd1, 12'h900);
    check_ret("st");

    // Fall-through branches until the narrow counter wraps to zero
    while (exp_ret < (1 << W)) run_branch("br_none", 1'b0, 1'b0, 1'b0, 12'h044);
    check("wrap_instret", 32'(instret), 32'd0);

    // Reset in the middle of a memory request
    set_op(7'b0000011, 1'b1, 1'b0);
    tick; tick; tick;
    mem_ready = 1'b0;
    expect_st("rstmem_mem", 3'd4, 12'hA10);
    reset = 1'b1;
    #1;
    exp_ret = 0;
    check("rstmem_req", 32'(mem_req), 32'd0);
    check("rstmem_state", 32'(state), 32'd0);
    check_ret("rstmem");
    tick;
    reset = 1'b0;
    expect_st("rstmem_idle", 3'd0, 12'h000);
    tick; expect_st("rstmem_fetch", 3'd1, 12'h800);
    mem_ready = 1'b1;

    // Unsupported opcode
    set_op(7'b1111111, 1'b0, 1'b0);
    expect_st("ill_fetch", 3'd1, 12'h900);
`ifdef TRAP_ILLEGAL_EN
    tick; expect_st("ill_decode", 3'd2, 12'h000);
    check("ill_flag_pre", 32'(illegal), 32'd0);
    tick; expect_st("ill_halt", 3'd6, 12'h000);
    check("ill_flag", 32'(illegal), 32'd1);
    check_ret("ill");
    for (int i = 0; i < 20; i++) begin
      tick;
      if (mem_req !== 1'b0 || state !== 3'd6) check("ill_hold", {state, mem_req}, 32'hC);
    end
    check("ill_hold_end", 32'({state, mem_req, illegal}), 32'hD);
`else
    tick; expect_st("nop_decode", 3'd2, 12'h040);
    tick; exp_ret++;
    expect_st("nop_next", 3'd1, 12'h900);
    check_ret("nop");
    check("nop_illegal", 32'(illegal), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
